// File: rtl/bitset_pkg.sv
// Shared widths and FSM state encoding for the bitset arbiter.
package bitset_pkg;

   localparam int WORD_W = 4;
   localparam int IDX_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_SWEEP = 2'd2
   } state_t;

endpackage

// File: rtl/bitset.sv
// Combinational bit replace: next_word is word with bit 'index' set to 'value'.
module bitset
   import bitset_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [IDX_W-1:0]  index,
   input  logic              value,
   output logic [WORD_W-1:0] next_word
);

   // Copy the word, then overwrite the single targeted bit.
   always_comb begin
      next_word        = word;
      next_word[index] = value;
   end

endmodule

// File: rtl/bitset_arbiter.sv
// Arbitrates single-bit writes from requesters A and B and a four-bit sweep
// onto one held 4-bit word. A/B writes take one WRITE cycle; a sweep walks
// the word LSB to MSB over four SWEEP cycles. done pulses after the last write.
//
// Handshake: a command transfers on a rising edge where valid and ready are
// both high. Ready is only ever raised in IDLE, is a grant (it is never high
// for a requester that is not asking), and at most one ready is high per
// cycle. Inputs are only sampled at that transfer; they are ignored while busy.
module bitset_arbiter
   import bitset_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VAL = 4'b0000
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [IDX_W-1:0]  a_index,
   input  logic              a_value,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [IDX_W-1:0]  b_index,
   input  logic              b_value,
   output logic              b_ready,
   input  logic              sweep_valid,
   input  logic              sweep_value,
   output logic              sweep_ready,
   output logic [WORD_W-1:0] word_q,
   output logic              busy,
   output logic              done,
   output state_t            fsm_state
);

   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(WORD_W - 1);

   state_t              state;
   state_t              state_nxt;
   logic                favour_b;    // round-robin pointer: 1 means B wins a tie
   logic [IDX_W-1:0]    cnt;
   logic [IDX_W-1:0]    cap_index;
   logic                cap_value;
   logic                done_r;
   logic [WORD_W-1:0]   word_r;
   logic [IDX_W-1:0]    bs_index;
   logic [WORD_W-1:0]   bs_next;

   // A sweep walks the counter; a single write uses the captured index.
   assign bs_index = (state == ST_SWEEP) ? cnt : cap_index;

   bitset u_bitset (
      .word      (word_r),
      .index     (bs_index),
      .value     (cap_value),
      .next_word (bs_next)
   );

   // Next-state and grant decode: sweep first, then round-robin between A and B.
   always_comb begin
      state_nxt   = state;
      a_ready     = 1'b0;
      b_ready     = 1'b0;
      sweep_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sweep_valid) begin
               sweep_ready = 1'b1;
               state_nxt   = ST_SWEEP;
            end else if (a_valid && (!favour_b || !b_valid)) begin
               a_ready   = 1'b1;
               state_nxt = ST_WRITE;
            end else if (b_valid) begin
               b_ready   = 1'b1;
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: state_nxt = ST_IDLE;
         ST_SWEEP: begin
            if (cnt == CNT_LAST) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State, capture registers, pointer, counter, held word and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         favour_b  <= 1'b0;
         cnt       <= '0;
         cap_index <= '0;
         cap_value <= 1'b0;
         done_r    <= 1'b0;
         word_r    <= RESET_VAL;
      end else begin
         state  <= state_nxt;
         done_r <= (state == ST_WRITE) || ((state == ST_SWEEP) && (cnt == CNT_LAST));
         if (sweep_ready) begin
            cap_value <= sweep_value;
            cnt       <= '0;
         end
         if (a_ready) begin
            cap_index <= a_index;
            cap_value <= a_value;
            favour_b  <= 1'b1;
         end
         if (b_ready) begin
            cap_index <= b_index;
            cap_value <= b_value;
            favour_b  <= 1'b0;
         end
         if (state == ST_WRITE) begin
            word_r <= bs_next;
         end
         if (state == ST_SWEEP) begin
            word_r <= bs_next;
            cnt    <= cnt + IDX_W'(1);
         end
      end
   end

   assign word_q    = word_r;
   assign busy      = (state != ST_IDLE);
   assign done      = done_r;
   assign fsm_state = state;

endmodule

// File: tb/tb_bitset_arbiter.sv
// Self-checking bench for bitset_arbiter: directed scenarios followed by
// random traffic, all checked each cycle against a queue-based reference.
module tb_bitset_arbiter;
   import bitset_pkg::*;

   localparam logic [3:0] RESET_VAL = 4'b0000;

   // Clock and reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_valid, a_value, b_valid, b_value, sweep_valid, sweep_value;
   logic [1:0] a_index, b_index;
   logic       a_ready, b_ready, sweep_ready, busy, done;
   logic [3:0] word_q;
   state_t     fsm_state;

   bitset_arbiter #(.RESET_VAL(RESET_VAL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_valid     (a_valid),
      .a_index     (a_index),
      .a_value     (a_value),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_index     (b_index),
      .b_value     (b_value),
      .b_ready     (b_ready),
      .sweep_valid (sweep_valid),
      .sweep_value (sweep_value),
      .sweep_ready (sweep_ready),
      .word_q      (word_q),
      .busy        (busy),
      .done        (done),
      .fsm_state   (fsm_state)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the word as seen now, the words still to appear on
   // coming edges for the command in flight, who was granted last, and
   // whether a done pulse is due this cycle.
   logic [3:0] m_word;
   logic [3:0] exp_q[$];
   logic       m_last_b;
   logic       m_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_word   = RESET_VAL;
      exp_q.delete();
      m_last_b = 1'b1;   // A is favoured after reset
      m_done   = 1'b0;
   endtask

   // Who should be granted right now, from the arbitration rules.
   task automatic model_grant(output logic ea, output logic eb, output logic es);
      logic idle;
      idle = (exp_q.size() == 0);
      es = idle && sweep_valid;
      ea = idle && !sweep_valid && a_valid && (!b_valid || m_last_b);
      eb = idle && !sweep_valid && b_valid && (!a_valid || !m_last_b);
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      logic ea, eb, es;
      logic [3:0] w;
      @(negedge clk);
      model_grant(ea, eb, es);
      chk("a_ready", a_ready, ea);
      chk("b_ready", b_ready, eb);
      chk("sweep_ready", sweep_ready, es);
      chk("busy", busy, exp_q.size() != 0);
      chk("done", done, m_done);
      chk("word_q", word_q, m_word);
      @(posedge clk);
      m_done = 1'b0;
      if (exp_q.size() != 0) begin
         m_word = exp_q.pop_front();
         if (exp_q.size() == 0) m_done = 1'b1;
      end else if (es) begin
         w = m_word;
         for (int k = 0; k < 4; k++) begin
            w[k] = sweep_value;
            exp_q.push_back(w);
         end
      end else if (ea) begin
         w = m_word;
         w[a_index] = a_value;
         exp_q.push_back(w);
         m_last_b = 1'b0;
      end else if (eb) begin
         w = m_word;
         w[b_index] = b_value;
         exp_q.push_back(w);
         m_last_b = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 0; b_valid = 0; sweep_valid = 0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_word"}, word_q, RESET_VAL);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_state"}, fsm_state, ST_IDLE);
   endtask

   initial begin
      idle_inputs();
      a_index = 0; a_value = 0; b_index = 0; b_value = 0; sweep_value = 0;
      model_reset();

      // Power-on reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("por");
      rst_n = 1'b1;

      // A writes 1 to bit 2 -> 0100 two edges after acceptance
      a_valid = 1; a_index = 2; a_value = 1;
      cycle();
      a_valid = 0;
      cycle();
      chk("r040_word", word_q, 4'b0100);
      chk("r040_done", done, 1'b1);
      cycle();
      cycle();

      // A=(0,1) and B=(2,0) held: B, A, B every two cycles
      a_valid = 1; a_index = 0; a_value = 1;
      b_valid = 1; b_index = 2; b_value = 0;
      repeat (6) cycle();
      idle_inputs();
      chk("r041_word", word_q, 4'b0001);
      cycle();

      // Clear bit 0, then sweep ones across the word
      a_valid = 1; a_index = 0; a_value = 0;
      cycle();
      idle_inputs();
      cycle();
      chk("pre_sweep_word", word_q, 4'b0000);
      sweep_valid = 1; sweep_value = 1;
      cycle();
      sweep_valid = 0;
      repeat (4) cycle();
      chk("r042_word", word_q, 4'b1111);
      cycle();

      // Sweep and A together: sweep wins, A follows in the done cycle
      sweep_valid = 1; sweep_value = 0;
      a_valid = 1; a_index = 3; a_value = 1;
      cycle();
      sweep_valid = 0;
      repeat (5) cycle();
      a_valid = 0;
      cycle();
      chk("r043_word", word_q, 4'b1000);
      cycle();

      // Writing an equal value leaves the word alone but still completes
      a_valid = 1; a_index = 3; a_value = 1;
      cycle();
      a_valid = 0;
      cycle();
      chk("r045_word", word_q, 4'b1000);
      chk("r045_done", done, 1'b1);
      cycle();

      // Sweep requested while a write is in flight is served next
      b_valid = 1; b_index = 1; b_value = 1;
      cycle();
      sweep_valid = 1; sweep_value = 1; a_valid = 1; a_index = 0; a_value = 0;
      cycle();
      chk("r033_sweep_ready", sweep_ready, 1'b1);
      idle_inputs();
      repeat (6) cycle();

      // Reset in the second sweep cycle abandons the sweep
      sweep_valid = 1; sweep_value = 0;
      cycle();
      sweep_valid = 0;
      cycle();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("r044");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         a_valid     = ($urandom_range(0, 99) < 55);
         b_valid     = ($urandom_range(0, 99) < 55);
         sweep_valid = ($urandom_range(0, 99) < 10);
         a_index     = 2'($urandom_range(0, 3));
         b_index     = 2'($urandom_range(0, 3));
         a_value     = 1'($urandom_range(0, 1));
         b_value     = 1'($urandom_range(0, 1));
         sweep_value = 1'($urandom_range(0, 1));
         cycle();
      end
      idle_inputs();
      repeat (6) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
